// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the sequential shift-add multiplier.
package mult_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } mult_state_t;

   // Step counter width: must hold WIDTH-1, never narrower than one bit.
   function automatic int cnt_w(input int w);
      return ($clog2(w) < 1) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/seq_shift_add_multiplier_if.sv
// Operand/result handshake bundle for the sequential multiplier.
interface seq_shift_add_multiplier_if #(
   parameter int WIDTH = 8
);
   logic               in_valid;
   logic               in_ready;
   logic [WIDTH-1:0]   a;
   logic [WIDTH-1:0]   b;
   logic               signed_mode;
   logic               out_valid;
   logic               out_ready;
   logic [2*WIDTH-1:0] product;
   logic               busy;

   modport master (
      output in_valid, a, b, signed_mode, out_ready,
      input  in_ready, out_valid, product, busy
   );

   modport slave (
      input  in_valid, a, b, signed_mode, out_ready,
      output in_ready, out_valid, product, busy
   );
endinterface

// File: rtl/mult_sign_mag.sv
// Sign/magnitude split of a two's complement or unsigned value. The same
// negator also serves to re-apply the sign to the final product via force_neg.
module mult_sign_mag #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] operand,
   input  logic             signed_mode,
   input  logic             force_neg,
   output logic [WIDTH-1:0] magnitude,
   output logic             sign
);
   // The most negative value negates to itself, which read unsigned is its
   // true magnitude 2^(WIDTH-1), so no extra bit is needed.
   assign sign      = signed_mode & operand[WIDTH-1];
   assign magnitude = (sign | force_neg) ? (~operand + WIDTH'(1)) : operand;
endmodule

// File: rtl/seq_shift_add_multiplier.sv
// Iterative WIDTH x WIDTH multiplier: magnitudes are multiplied one
// multiplier bit per clock (LSB first), the sign is applied at the end.
module seq_shift_add_multiplier
   import mult_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   seq_shift_add_multiplier_if.slave  bus
);
   localparam int PW    = 2 * WIDTH;
   localparam int CNT_W = cnt_w(WIDTH);

   mult_state_t       state;
   logic [WIDTH-1:0]  mag_a;      // multiplicand magnitude
   logic [WIDTH-1:0]  mag_b;      // multiplier magnitude, consumed LSB first
   logic              neg;        // result must be negated
   logic [CNT_W-1:0]  cnt;
   logic [PW-1:0]     acc;
   logic              out_valid_q;
   logic [PW-1:0]     product_q;

   logic [WIDTH-1:0]  op_a_mag, op_b_mag;
   logic              op_a_sign, op_b_sign;
   logic [WIDTH:0]    sum;
   logic [PW-1:0]     acc_next;
   logic [PW-1:0]     prod_fix;
   logic              prod_sign_unused;

   mult_sign_mag #(.WIDTH(WIDTH)) u_sm_a (
      .operand     (bus.a),
      .signed_mode (bus.signed_mode),
      .force_neg   (1'b0),
      .magnitude   (op_a_mag),
      .sign        (op_a_sign)
   );

   mult_sign_mag #(.WIDTH(WIDTH)) u_sm_b (
      .operand     (bus.b),
      .signed_mode (bus.signed_mode),
      .force_neg   (1'b0),
      .magnitude   (op_b_mag),
      .sign        (op_b_sign)
   );

   // Add the multiplicand into the upper half when the current multiplier bit
   // is set; the carry becomes the new MSB as the accumulator shifts right.
   assign sum      = {1'b0, acc[PW-1:WIDTH]} + {1'b0, (mag_b[0] ? mag_a : '0)};
   assign acc_next = {sum, acc[WIDTH-1:1]};

   // Final sign correction on the full-width result.
   mult_sign_mag #(.WIDTH(PW)) u_sm_p (
      .operand     (acc_next),
      .signed_mode (1'b0),
      .force_neg   (neg),
      .magnitude   (prod_fix),
      .sign        (prod_sign_unused)
   );

   // Handshake status is decoded from state alone.
   assign bus.in_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.product   = product_q;

   // Control FSM and datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         mag_a       <= '0;
         mag_b       <= '0;
         neg         <= 1'b0;
         cnt         <= '0;
         acc         <= '0;
         out_valid_q <= 1'b0;
         product_q   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  mag_a <= op_a_mag;
                  mag_b <= op_b_mag;
                  neg   <= op_a_sign ^ op_b_sign;
                  acc   <= '0;
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               acc   <= acc_next;
               mag_b <= mag_b >> 1;
               cnt   <= cnt + CNT_W'(1);
               if (cnt == CNT_W'(WIDTH - 1)) begin
                  product_q   <= prod_fix;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (bus.out_ready) begin
                  out_valid_q <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Self-checking bench: cycle-level behavioural model for the WIDTH=8 instance,
// literal expectations, random operations and an exhaustive WIDTH=4 sweep.
module tb_seq_shift_add_multiplier;
   logic clk;
   logic rst_n;
   int   checks   = 0;
   int   failures = 0;
   bit   chk_en   = 1'b0;
   int   cyc      = 0;

   seq_shift_add_multiplier_if #(.WIDTH(8)) b8 ();
   seq_shift_add_multiplier_if #(.WIDTH(4)) b4 ();

   seq_shift_add_multiplier #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
   seq_shift_add_multiplier #(.WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4.slave));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Exact product by plain integer arithmetic, truncated to 2*w bits.
   function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a,
                                           input logic [15:0] b, input bit sm);
      longint av, bv, p;
      av = longint'(a);
      bv = longint'(b);
      if (sm && a[w-1]) av = av - (longint'(1) << w);
      if (sm && b[w-1]) bv = bv - (longint'(1) << w);
      p = av * bv;
      return 32'(p & ((longint'(1) << (2 * w)) - 1));
   endfunction

   // Model of the WIDTH=8 instance: result appears 8 edges after acceptance
   // and is held until taken; inputs are ignored while an operation is open.
   logic        m_busy, m_outv;
   logic [15:0] m_exp, m_prod;
   int          m_acc;
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0; m_outv <= 1'b0; m_prod <= '0; m_exp <= '0; m_acc <= 0;
      end else if (!m_busy) begin
         if (b8.in_valid) begin
            m_busy <= 1'b1;
            m_acc  <= cyc;
            m_exp  <= 16'(ref_mul(8, {8'h0, b8.a}, {8'h0, b8.b}, b8.signed_mode));
         end
      end else if (m_outv) begin
         if (b8.out_ready) begin m_outv <= 1'b0; m_busy <= 1'b0; end
      end else if (cyc - m_acc == 8) begin
         m_outv <= 1'b1;
         m_prod <= m_exp;
      end
   end

   // Compare the WIDTH=8 outputs against the model on every cycle.
   always @(negedge clk) begin
      if (chk_en && rst_n) begin
         chk("cmp_in_ready",  32'(b8.in_ready),  32'(!m_busy));
         chk("cmp_busy",      32'(b8.busy),      32'(m_busy));
         chk("cmp_out_valid", 32'(b8.out_valid), 32'(m_outv));
         chk("cmp_product",   32'(b8.product),   32'(m_prod));
      end
   end

   task automatic op8(input logic [7:0] a, input logic [7:0] b, input bit sm,
                      input int hold, output logic [15:0] p, output int lat);
      @(negedge clk);
      chk("accept_ready", 32'(b8.in_ready), 32'd1);
      b8.in_valid = 1'b1; b8.a = a; b8.b = b; b8.signed_mode = sm;
      @(posedge clk);
      @(negedge clk);
      b8.in_valid = 1'b0;
      b8.a = 8'($urandom); b8.b = 8'($urandom); b8.signed_mode = 1'($urandom);
      lat = 0;
      while (!b8.out_valid && lat < 40) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      if (!b8.out_valid) chk("op8_timeout", 32'd0, 32'd1);
      p = b8.product;
      for (int i = 0; i < hold; i++) begin
         if (i == 1) begin b8.in_valid = 1'b1; b8.a = 8'h01; b8.b = 8'h01; end
         else b8.in_valid = 1'b0;
         @(posedge clk); @(negedge clk);
         chk("hold_product", 32'(b8.product),  32'(p));
         chk("hold_valid",   32'(b8.out_valid), 32'd1);
         chk("hold_busy",    32'(b8.busy),      32'd1);
         chk("hold_ready",   32'(b8.in_ready),  32'd0);
      end
      b8.in_valid  = 1'b0;
      b8.out_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      b8.out_ready = 1'b0;
   endtask

   task automatic lit8(input string nm, input logic [7:0] a, input logic [7:0] b,
                       input bit sm, input int hold, input logic [15:0] exp);
      logic [15:0] p;
      int          lat;
      op8(a, b, sm, hold, p, lat);
      chk(nm, 32'(p), 32'(exp));
      chk({nm, "_model"}, 32'(m_prod), 32'(exp));
      chk({nm, "_latency"}, 32'(lat), 32'd8);
   endtask

   task automatic op4(input logic [3:0] a, input logic [3:0] b, input bit sm,
                      output logic [7:0] p, output int lat);
      @(negedge clk);
      b4.in_valid = 1'b1; b4.a = a; b4.b = b; b4.signed_mode = sm;
      @(posedge clk);
      @(negedge clk);
      b4.in_valid = 1'b0;
      lat = 0;
      while (!b4.out_valid && lat < 20) begin
         @(posedge clk); lat++; @(negedge clk);
      end
      if (!b4.out_valid) chk("op4_timeout", 32'd0, 32'd1);
      p = b4.product;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired t=%0t", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] p;
      logic [7:0]  p4;
      logic [7:0]  ra, rb;
      bit          rs;
      int          lat;

      rst_n = 1'b0;
      b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.signed_mode = 1'b0; b8.out_ready = 1'b0;
      b4.in_valid = 1'b0; b4.a = '0; b4.b = '0; b4.signed_mode = 1'b0; b4.out_ready = 1'b1;
      #2;
      chk("reset_in_ready",  32'(b8.in_ready),  32'd1);
      chk("reset_busy",      32'(b8.busy),      32'd0);
      chk("reset_out_valid", 32'(b8.out_valid), 32'd0);
      chk("reset_product",   32'(b8.product),   32'd0);
      #11 rst_n = 1'b1;
      chk_en = 1'b1;

      lit8("u_13x11",     8'd13,  8'd11,  1'b0, 0, 16'h008F);
      lit8("s_m3x5",      8'hFD,  8'h05,  1'b1, 0, 16'hFFF1);
      lit8("s_min_x_min", 8'h80,  8'h80,  1'b1, 0, 16'h4000);
      lit8("u_80x80",     8'h80,  8'h80,  1'b0, 0, 16'h4000);
      lit8("u_ffxff",     8'hFF,  8'hFF,  1'b0, 0, 16'hFE01);
      lit8("s_zero",      8'h00,  8'hFF,  1'b1, 0, 16'h0000);
      lit8("s_m1xm1",     8'hFF,  8'hFF,  1'b1, 0, 16'h0001);
      lit8("s_min_x_max", 8'h80,  8'h7F,  1'b1, 0, 16'hC080);
      // Backpressure with a stray in_valid pulse, then back-to-back accept.
      lit8("bp_hold",     8'd25,  8'd9,   1'b0, 5, 16'h00E1);
      lit8("bp_next",     8'hF6,  8'd10,  1'b1, 0, 16'hFF9C);

      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rs = 1'($urandom);
         op8(ra, rb, rs, int'($urandom_range(0, 3)), p, lat);
         chk("rand_product", 32'(p), ref_mul(8, {8'h0, ra}, {8'h0, rb}, rs));
         chk("rand_latency", 32'(lat), 32'd8);
      end

      // Abort an operation with reset in the middle of RUN.
      lit8("pre_rst",     8'd3,   8'd3,   1'b0, 0, 16'h0009);
      @(negedge clk);
      b8.in_valid = 1'b1; b8.a = 8'hAB; b8.b = 8'hCD; b8.signed_mode = 1'b0;
      @(posedge clk);
      @(negedge clk);
      b8.in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_in_ready",  32'(b8.in_ready),  32'd1);
      chk("abort_busy",      32'(b8.busy),      32'd0);
      chk("abort_out_valid", 32'(b8.out_valid), 32'd0);
      chk("abort_product",   32'(b8.product),   32'd0);
      @(negedge clk);
      #3 rst_n = 1'b1;
      lit8("after_rst_7x6", 8'd7, 8'd6, 1'b0, 0, 16'h002A);

      // Exhaustive WIDTH=4 sweep in both modes.
      for (int m = 0; m < 2; m++) begin
         for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
               op4(4'(x), 4'(y), 1'(m), p4, lat);
               chk("w4_product", 32'(p4), ref_mul(4, 16'(x), 16'(y), 1'(m)));
               chk("w4_latency", 32'(lat), 32'd4);
            end
         end
      end

      @(negedge clk);
      chk_en = 1'b0;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
